// File: rtl/vram_arb_pkg.sv
// Shared types and widths for the VRAM arbiter: owner tags for the read-return
// pipeline and default VRAM geometry.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_REG,
    OWN_AUX
  } vram_owner_t;

  localparam int RR_REG = 0;
  localparam int RR_AUX = 1;

endpackage

// File: rtl/vram_arb_if.sv
// Requester + VRAM bus bundle for vram_arb. slave = arbiter view,
// master = requesters/memory view.
interface vram_arb_if
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int STALL_W = 16
) ();

  logic              vid_sel_i;
  logic [ADDR_W-1:0] vid_addr_i;
  logic [DATA_W-1:0] vid_data_o;
  logic              vid_valid_o;

  logic              reg_req_i;
  logic              reg_wr_i;
  logic [ADDR_W-1:0] reg_addr_i;
  logic [DATA_W-1:0] reg_data_i;
  logic              reg_ack_o;
  logic [DATA_W-1:0] reg_data_o;
  logic              reg_valid_o;

  logic              aux_req_i;
  logic              aux_wr_i;
  logic [ADDR_W-1:0] aux_addr_i;
  logic [DATA_W-1:0] aux_data_i;
  logic              aux_ack_o;
  logic [DATA_W-1:0] aux_data_o;
  logic              aux_valid_o;

  logic              vram_sel_o;
  logic              vram_wr_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_data_o;
  logic [DATA_W-1:0] vram_data_i;

  logic [STALL_W-1:0] stall_count_o;

  modport slave (
    input  vid_sel_i, vid_addr_i,
    output vid_data_o, vid_valid_o,
    input  reg_req_i, reg_wr_i, reg_addr_i, reg_data_i,
    output reg_ack_o, reg_data_o, reg_valid_o,
    input  aux_req_i, aux_wr_i, aux_addr_i, aux_data_i,
    output aux_ack_o, aux_data_o, aux_valid_o,
    output vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
    input  vram_data_i,
    output stall_count_o
  );

  modport master (
    output vid_sel_i, vid_addr_i,
    input  vid_data_o, vid_valid_o,
    output reg_req_i, reg_wr_i, reg_addr_i, reg_data_i,
    input  reg_ack_o, reg_data_o, reg_valid_o,
    output aux_req_i, aux_wr_i, aux_addr_i, aux_data_i,
    input  aux_ack_o, aux_data_o, aux_valid_o,
    input  vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
    output vram_data_i,
    input  stall_count_o
  );

endinterface

// File: rtl/vram_arb_rr.sv
// Two-way round-robin picker for the reg (bit 0) and aux (bit 1) requesters.
// ptr=1 means aux has priority on the next tie.
module vram_arb_rr (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic [1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // The winner drops to lower priority, so a sole winner never earns a second
  // tie in a row.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: video has absolute priority, reg and aux share the
// remaining slots round-robin. Define VRAM_ARB_STATS_EN to build the stall counter.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int STALL_W = 16
) (
  input logic       clk,
  input logic       reset_i,
  vram_arb_if.slave bus
);

  logic [1:0]        rr_req;
  logic [1:0]        rr_mask;
  logic [1:0]        rr_grant;
  logic              rr_ptr;

  logic              sel_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              reg_ack_q;
  logic              aux_ack_q;
  vram_owner_t       owner_q;

  logic              vid_valid_q;
  logic              reg_valid_q;
  logic              aux_valid_q;
  logic [DATA_W-1:0] vid_hold_q;
  logic [DATA_W-1:0] reg_hold_q;
  logic [DATA_W-1:0] aux_hold_q;

  assign rr_req  = {bus.aux_req_i, bus.reg_req_i};
  // A requester acked this cycle still shows req high; keep it out of the next pick.
  assign rr_mask = {aux_ack_q, reg_ack_q};

  vram_arb_rr u_rr (
    .clk     (clk),
    .reset_i (reset_i),
    .req     (rr_req),
    .mask    (rr_mask),
    .advance (!bus.vid_sel_i),
    .grant   (rr_grant),
    .ptr     (rr_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      reg_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      owner_q     <= OWN_NONE;
      vid_valid_q <= 1'b0;
      reg_valid_q <= 1'b0;
      aux_valid_q <= 1'b0;
      vid_hold_q  <= '0;
      reg_hold_q  <= '0;
      aux_hold_q  <= '0;
    end else begin
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      reg_ack_q <= 1'b0;
      aux_ack_q <= 1'b0;
      owner_q   <= OWN_NONE;

      if (bus.vid_sel_i) begin
        sel_q   <= 1'b1;
        addr_q  <= bus.vid_addr_i;
        owner_q <= OWN_VID;
      end else if (rr_grant[RR_REG]) begin
        sel_q     <= 1'b1;
        wr_q      <= bus.reg_wr_i;
        addr_q    <= bus.reg_addr_i;
        reg_ack_q <= 1'b1;
        owner_q   <= bus.reg_wr_i ? OWN_NONE : OWN_REG;
        if (bus.reg_wr_i) begin
          data_q <= bus.reg_data_i;
        end
      end else if (rr_grant[RR_AUX]) begin
        sel_q     <= 1'b1;
        wr_q      <= bus.aux_wr_i;
        addr_q    <= bus.aux_addr_i;
        aux_ack_q <= 1'b1;
        owner_q   <= bus.aux_wr_i ? OWN_NONE : OWN_AUX;
        if (bus.aux_wr_i) begin
          data_q <= bus.aux_data_i;
        end
      end

      // Memory answers the cycle after the access, so the tag is one stage behind.
      vid_valid_q <= (owner_q == OWN_VID);
      reg_valid_q <= (owner_q == OWN_REG);
      aux_valid_q <= (owner_q == OWN_AUX);

      if (vid_valid_q) vid_hold_q <= bus.vram_data_i;
      if (reg_valid_q) reg_hold_q <= bus.vram_data_i;
      if (aux_valid_q) aux_hold_q <= bus.vram_data_i;
    end
  end

  assign bus.vram_sel_o  = sel_q;
  assign bus.vram_wr_o   = wr_q;
  assign bus.vram_addr_o = addr_q;
  assign bus.vram_data_o = data_q;
  assign bus.reg_ack_o   = reg_ack_q;
  assign bus.aux_ack_o   = aux_ack_q;

  assign bus.vid_valid_o = vid_valid_q;
  assign bus.reg_valid_o = reg_valid_q;
  assign bus.aux_valid_o = aux_valid_q;
  assign bus.vid_data_o  = vid_valid_q ? bus.vram_data_i : vid_hold_q;
  assign bus.reg_data_o  = reg_valid_q ? bus.vram_data_i : reg_hold_q;
  assign bus.aux_data_o  = aux_valid_q ? bus.vram_data_i : aux_hold_q;

`ifdef VRAM_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q;
  logic               stall_now;

  assign stall_now = (|(rr_req & ~rr_mask)) && (bus.vid_sel_i || (rr_grant == 2'b00));

  always_ff @(posedge clk) begin
    if (reset_i) begin
      stall_q <= '0;
    end else if (stall_now && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_count_o = stall_q;
`else
  assign bus.stall_count_o = {STALL_W{1'b0}};
`endif

  // An ack means that requester just won, so it must now be the lower-priority side.
  a_rr_reg: assert property (@(posedge clk) disable iff (reset_i) bus.reg_ack_o |-> rr_ptr);
  a_rr_aux: assert property (@(posedge clk) disable iff (reset_i) bus.aux_ack_o |-> !rr_ptr);

endmodule
